jogador_automatico: RTL

Automatic player for the memory game circuit: the player-side end of the jogar/botoes/ganhou/perdeu interface. It starts a game, then replays a fixed 16-move sequence in incremental rounds. Round r presses moves 0..r, with programmable press width and release gap. It stops on the game's ganhou/perdeu result or on a watchdog timeout, so hardware self-test runs on the board without a human player.

---
 rtl/jogador_automatico.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: starts a game and replays a fixed 16-move
// sequence in incremental rounds. Optional wrong-move injection via JOGADOR_ERRO_EN.
module jogador_automatico #(
    parameter int unsigned PRESS_CYCLES   = 10,
    parameter int unsigned GAP_CYCLES     = 10,
    parameter int unsigned START_CYCLES   = 5,
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       ganhou,
    input  logic       perdeu,
`ifdef JOGADOR_ERRO_EN
    input  logic       erro_en,
    input  logic [3:0] erro_rodada,
`endif
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ativo,
    output logic       fim,
    output logic       ganhou_visto,
    output logic       perdeu_visto,
    output logic       esgotou,
    output logic [3:0] rodada,
    output logic [3:0] indice,
    output logic [3:0] db_estado
);

    localparam int unsigned MAX_PS      = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_ST      = (START_CYCLES > TIMEOUT_CYCLES) ? START_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MAX_CYCLES  = (MAX_PS > MAX_ST) ? MAX_PS : MAX_ST;
    localparam int unsigned CNT_W       = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam int unsigned ULTIMA      = 15;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        JOGAR       = 4'h1,
        ESPERA      = 4'h2,
        APERTA      = 4'h3,
        SOLTA       = 4'h4,
        AGUARDA     = 4'h7,
        FIM_GANHOU  = 4'hA,
        FIM_PERDEU  = 4'hE,
        FIM_TIMEOUT = 4'hF
    } estado_t;

    estado_t            state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [3:0]         rodada_n, indice_n;
    logic [3:0]         jogada_n;
    logic               resultado;
    estado_t            fim_resultado;

    function automatic logic [3:0] rom_jogada(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd6, 4'd7, 4'd14:          rom_jogada = 4'b0001;
            4'd1, 4'd5, 4'd8, 4'd9:           rom_jogada = 4'b0010;
            4'd2, 4'd4, 4'd10, 4'd11, 4'd15:  rom_jogada = 4'b0100;
            default:                          rom_jogada = 4'b1000;
        endcase
    endfunction

    assign resultado     = ganhou | perdeu;
    assign fim_resultado = perdeu ? FIM_PERDEU : FIM_GANHOU;

    // Next-state, shared down-counter and round/move bookkeeping
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rodada_n = rodada;
        indice_n = indice;
        case (state)
            INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
                if (iniciar) begin
                    state_n  = JOGAR;
                    cnt_n    = CNT_W'(START_CYCLES - 1);
                    rodada_n = '0;
                    indice_n = '0;
                end
            end
            JOGAR: begin
                if (resultado)            state_n = fim_resultado;
                else if (cnt == '0) begin
                    state_n = ESPERA;
                    cnt_n   = CNT_W'(GAP_CYCLES - 1);
                end else                  cnt_n = cnt - CNT_W'(1);
            end
            ESPERA: begin
                if (resultado)            state_n = fim_resultado;
                else if (cnt == '0) begin
                    state_n = APERTA;
                    cnt_n   = CNT_W'(PRESS_CYCLES - 1);
                end else                  cnt_n = cnt - CNT_W'(1);
            end
            APERTA: begin
                if (resultado)            state_n = fim_resultado;
                else if (cnt == '0) begin
                    state_n = SOLTA;
                    cnt_n   = CNT_W'(GAP_CYCLES - 1);
                end else                  cnt_n = cnt - CNT_W'(1);
            end
            SOLTA: begin
                if (resultado)            state_n = fim_resultado;
                else if (cnt == '0) begin
                    if (indice < rodada) begin
                        state_n  = APERTA;
                        cnt_n    = CNT_W'(PRESS_CYCLES - 1);
                        indice_n = indice + 4'd1;
                    end else if (rodada != 4'(ULTIMA)) begin
                        state_n  = APERTA;
                        cnt_n    = CNT_W'(PRESS_CYCLES - 1);
                        rodada_n = rodada + 4'd1;
                        indice_n = '0;
                    end else begin
                        state_n = AGUARDA;
                        cnt_n   = CNT_W'(TIMEOUT_CYCLES - 1);
                    end
                end else                  cnt_n = cnt - CNT_W'(1);
            end
            AGUARDA: begin
                if (resultado)            state_n = fim_resultado;
                else if (cnt == '0)       state_n = FIM_TIMEOUT;
                else                      cnt_n = cnt - CNT_W'(1);
            end
            default:                      state_n = INICIAL;
        endcase
    end

    // Move driven during the upcoming press, optionally corrupted on the last press of one round
    always_comb begin
        jogada_n = rom_jogada(indice_n);
`ifdef JOGADOR_ERRO_EN
        if (erro_en && (rodada_n == erro_rodada) && (indice_n == rodada_n))
            jogada_n = {jogada_n[2:0], jogada_n[3]};
`endif
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= INICIAL;
            cnt          <= '0;
            rodada       <= '0;
            indice       <= '0;
            jogar        <= 1'b0;
            botoes       <= '0;
            ativo        <= 1'b0;
            fim          <= 1'b0;
            ganhou_visto <= 1'b0;
            perdeu_visto <= 1'b0;
            esgotou      <= 1'b0;
            db_estado    <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            rodada       <= rodada_n;
            indice       <= indice_n;
            jogar        <= (state_n == JOGAR);
            botoes       <= (state_n == APERTA) ? jogada_n : 4'b0000;
            ativo        <= (state_n inside {JOGAR, ESPERA, APERTA, SOLTA, AGUARDA});
            fim          <= (state_n inside {FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT});
            ganhou_visto <= (state_n == FIM_GANHOU);
            perdeu_visto <= (state_n == FIM_PERDEU);
            esgotou      <= (state_n == FIM_TIMEOUT);
            db_estado    <= state_n;
        end
    end

endmodule
